// File: rtl/lsu_pkg.sv
// Shared types for the dual-issue load/store unit: access sizes and the queued op record.
package lsu_pkg;

  // Widest destination tag a queue entry can carry; narrower tags are zero-extended.
  localparam int LSU_TAG_MAX = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic                   is_store;
    mem_size_e              size;
    logic                   zero_ext;
    logic [31:0]            addr;
    logic [31:0]            wdata;
    logic [LSU_TAG_MAX-1:0] tag;
  } lsu_entry_t;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_queue.sv
// In-order op queue: up to two writes and one read per cycle, with a registered
// "at least two free entries" flag so the producer never overruns it.
module lsu_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] push,
  input  lsu_entry_t wr0_data,
  input  lsu_entry_t wr1_data,
  input  logic       pop,
  output lsu_entry_t head,
  output logic       empty,
  output logic       free_ge2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  lsu_entry_t    mem_q [DEPTH];
  lsu_entry_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          free_ge2_q, free_ge2_d;

  // push is thermometer coded (01 = one entry, 11 = two), so push[1] implies push[0].
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push[0]) begin
      mem_d[wr_ptr_q] = wr0_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (push[1]) begin
      mem_d[wr_ptr_q + PW'(1)] = wr1_data;
      wr_ptr_d                 = wr_ptr_q + PW'(2);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d    = count_q + CW'(push[0]) + CW'(push[1]) - CW'(pop);
    free_ge2_d = (count_d <= CW'(DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      free_ge2_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      free_ge2_q <= free_ge2_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign free_ge2 = free_ge2_q;

endmodule

// File: rtl/lsu_dual_issue.sv
// Dual-issue load/store unit: two ops per cycle into an in-order queue, one issue per cycle.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word ops are dropped with an err pulse.
module lsu_dual_issue
  import lsu_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int TAG_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_is_store,
  input  logic [1:0][1:0]       req_size,
  input  logic [1:0]            req_zero_ext,
  input  logic [1:0][31:0]      req_addr,
  input  logic [1:0][31:0]      req_wdata,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [31:0]           mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  mem_wr_en,
  output logic [1:0]            mem_wr_size,
  output logic [31:0]           mem_rd_addr,
  output logic                  mem_rd_en,
  output logic [1:0]            mem_rd_size,
  output logic                  mem_rd_zero_ext,
  input  logic [31:0]           mem_rd_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  err,
  output logic [31:0]           err_addr,
  output logic                  busy
);

  lsu_entry_t slot_e [2];
  lsu_entry_t head;
  logic [1:0] accept;
  logic       q_empty;
  logic       q_free_ge2;
  logic       head_valid, misalign, drop, do_st, do_ld;
  logic       unused_tag;

  logic [31:0]      wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [1:0]       wr_size_q, wr_size_d, rd_size_q, rd_size_d;
  logic [31:0]      rd_addr_q, rd_addr_d, err_addr_q, err_addr_d;
  logic             rd_zext_q, rd_zext_d;
  logic             pend_valid_q, pend_valid_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot_e[i].is_store = req_is_store[i];
      slot_e[i].size     = mem_size_e'(req_size[i]);
      slot_e[i].zero_ext = req_zero_ext[i];
      slot_e[i].addr     = req_addr[i];
      slot_e[i].wdata    = req_wdata[i];
      slot_e[i].tag      = LSU_TAG_MAX'(req_tag[i]);
    end
  end

  // A lone slot-1 op is steered onto write port 0 so the queue stays compact.
  assign accept = req_valid & {2{q_free_ge2}};

  lsu_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     ({&accept, |accept}),
    .wr0_data (accept[0] ? slot_e[0] : slot_e[1]),
    .wr1_data (slot_e[1]),
    .pop      (head_valid),
    .head     (head),
    .empty    (q_empty),
    .free_ge2 (q_free_ge2)
  );

  always_comb begin
    head_valid = !q_empty;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign   = is_misaligned(head.size, head.addr[1:0]);
`else
    misalign   = 1'b0;
`endif
    drop  = head_valid && ((head.size == SZ_ILL) || misalign);
    do_st = head_valid && !drop && head.is_store;
    do_ld = head_valid && !drop && !head.is_store;

    wr_addr_d    = do_st ? head.addr  : wr_addr_q;
    wr_data_d    = do_st ? head.wdata : wr_data_q;
    wr_size_d    = do_st ? head.size  : wr_size_q;
    rd_addr_d    = do_ld ? head.addr  : rd_addr_q;
    rd_size_d    = do_ld ? head.size  : rd_size_q;
    rd_zext_d    = do_ld ? head.zero_ext : rd_zext_q;
    err_addr_d   = drop  ? head.addr  : err_addr_q;
    pend_valid_d = do_ld;
    pend_tag_d   = do_ld ? head.tag[TAG_W-1:0] : pend_tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_size_q    <= '0;
      rd_addr_q    <= '0;
      rd_size_q    <= '0;
      rd_zext_q    <= 1'b0;
      err_addr_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_tag_q   <= '0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_size_q    <= wr_size_d;
      rd_addr_q    <= rd_addr_d;
      rd_size_q    <= rd_size_d;
      rd_zext_q    <= rd_zext_d;
      err_addr_q   <= err_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_tag_q   <= pend_tag_d;
    end
  end

  // The issuing op drives memory directly; between ops the last values are held.
  assign mem_wr_en       = do_st;
  assign mem_wr_addr     = wr_addr_d;
  assign mem_wr_data     = wr_data_d;
  assign mem_wr_size     = wr_size_d;
  assign mem_rd_en       = do_ld;
  assign mem_rd_addr     = rd_addr_d;
  assign mem_rd_size     = rd_size_d;
  assign mem_rd_zero_ext = rd_zext_d;

  assign err      = drop;
  assign err_addr = err_addr_d;

  assign resp_valid = pend_valid_q;
  assign resp_data  = pend_valid_q ? mem_rd_data : '0;
  assign resp_tag   = pend_tag_q;

  assign req_ready = q_free_ge2;
  assign busy      = head_valid || pend_valid_q;

  assign unused_tag = ^head.tag;

endmodule
